// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and load/store.
// Data side wins by default; a starvation counter forces a fetch grant after STARVE_MAX denials.
//
// prio state        | meaning
// PRIO_DATA         | data port has priority when both request
// PRIO_FETCH_FORCED | fetch has been starved; next fetch request wins
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic {PRIO_DATA, PRIO_FETCH_FORCED} prio_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;

  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  prio_e             prio_q, prio_d;
  owner_e            resp_owner_q, resp_owner_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (rst_n) begin
      if (if_req && (prio_q == PRIO_FETCH_FORCED || !d_req)) if_gnt = 1'b1;
      else if (d_req)                                        d_gnt  = 1'b1;
    end

    mem_addr       = if_gnt ? if_addr : d_addr;
    mem_write_en   = d_gnt & d_we;
    mem_write_data = d_wdata;

    if_rvalid = rst_n && (resp_owner_q == OWN_IF);
    d_rvalid  = rst_n && (resp_owner_q == OWN_D);
    if_rdata  = if_rvalid ? mem_read_data : if_rdata_q;
    d_rdata   = d_rvalid  ? mem_read_data : d_rdata_q;
    if_rdata_d = if_rdata;
    d_rdata_d  = d_rdata;

    if (if_req && !if_gnt)
      starve_cnt_d = (starve_cnt_q == CNT_MAX) ? starve_cnt_q : starve_cnt_q + CNT_W'(1);
    else
      starve_cnt_d = '0;

    // Forced priority holds until the fetch actually gets its grant.
    if (if_gnt)                        prio_d = PRIO_DATA;
    else if (starve_cnt_d == CNT_MAX)  prio_d = PRIO_FETCH_FORCED;
    else                               prio_d = prio_q;

    if (if_gnt)              resp_owner_d = OWN_IF;
    else if (d_gnt && !d_we) resp_owner_d = OWN_D;
    else                     resp_owner_d = OWN_NONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      prio_q       <= PRIO_DATA;
      resp_owner_q <= OWN_NONE;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      prio_q       <= prio_d;
      resp_owner_q <= resp_owner_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory and a response scoreboard.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_write_en;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_write_data, mem_read_data;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  int n_vec = 0;
  int n_err = 0;
  bit pend_i = 1'b0, pend_d = 1'b0;
  logic [31:0] last_i = '0, last_d = '0;
  logic [31:0] qi[$], qd[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_write_en(mem_write_en), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr[9:0]] <= mem_write_data;
    mem_read_data <= mem[mem_addr[9:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                     input logic [31:0] da, input logic [31:0] dwd);
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dwe;
    d_addr  = da;
    d_wdata = dwd;
  endtask

  // One clock cycle: check grants and responses, then record what this cycle's grant must return.
  task automatic cyc(input bit eig, input bit edg);
    logic [31:0] e;
    @(negedge clk);
    chk("if_gnt", {31'b0, if_gnt}, {31'b0, eig});
    chk("d_gnt", {31'b0, d_gnt}, {31'b0, edg});
    chk("mem_write_en", {31'b0, mem_write_en}, {31'b0, edg & d_we});
    if (eig) chk("mem_addr_if", mem_addr, if_addr);
    if (edg) chk("mem_addr_d", mem_addr, d_addr);
    if (edg && d_we) chk("mem_write_data", mem_write_data, d_wdata);

    chk("if_rvalid", {31'b0, if_rvalid}, {31'b0, pend_i & rst_n});
    chk("d_rvalid", {31'b0, d_rvalid}, {31'b0, pend_d & rst_n});
    if (pend_i) begin
      e = qi.pop_front();
      if (rst_n) begin
        chk("if_rdata", if_rdata, e);
        last_i = e;
      end
    end else if (rst_n) chk("if_rdata_hold", if_rdata, last_i);
    if (pend_d) begin
      e = qd.pop_front();
      if (rst_n) begin
        chk("d_rdata", d_rdata, e);
        last_d = e;
      end
    end else if (rst_n) chk("d_rdata_hold", d_rdata, last_d);
    if (!rst_n) begin
      last_i = '0;
      last_d = '0;
    end

    pend_i = eig;
    if (eig) qi.push_back(ref_mem[if_addr[9:0]]);
    pend_d = edg & ~d_we;
    if (edg && !d_we) qd.push_back(ref_mem[d_addr[9:0]]);
    if (edg && d_we) ref_mem[d_addr[9:0]] = d_wdata;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
      ref_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
    end
    mem[16]     = 32'h0050_0093;
    ref_mem[16] = 32'h0050_0093;

    rst_n = 1'b0;
    drv(1'b1, 32'h10, 1'b1, 1'b1, 32'h3F0, 32'h1122_3344);
    @(posedge clk);
    #1;

    // Reset gates everything even with both requesters (and a store) active.
    repeat (3) cyc(1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1);
    drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b0);

    // Single fetch.
    drv(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0);
    drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("t2_if_rdata", if_rdata, 32'h0050_0093);

    // Store then load of the same address.
    drv(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF);
    cyc(1'b0, 1'b1);
    drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0);
    cyc(1'b0, 1'b1);
    drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("t3_load_data", d_rdata, 32'hDEAD_BEEF);

    // Continuous contention: four data grants, then a forced fetch, repeating.
    drv(1'b1, 32'h10, 1'b1, 1'b0, 32'h200, 32'h0);
    for (int k = 0; k < 10; k++) cyc((k % 5) == 4, (k % 5) != 4);
    drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);

    // Back-to-back alternating owners.
    drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    cyc(1'b0, 1'b1);
    drv(1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0);
    drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0);
    cyc(1'b0, 1'b1);
    drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);

    // Reset right after a load grant drops the response.
    drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0);
    cyc(1'b0, 1'b1);
    drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    cyc(1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0);
    chk("t6_d_rdata", d_rdata, 32'h0);
    chk("t6_if_rdata", if_rdata, 32'h0);

    chk("qi_empty", 32'(qi.size()), 32'h0);
    chk("qd_empty", 32'(qd.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
